// File: rtl/hs_fifo_stage.sv
// hs_fifo_stage: elastic buffer between a req/ack producer (upstream) and a
// req/ack consumer (downstream).
//
// The upstream side acts as a consumer: it raises in_req, waits for an ack
// pulse and samples in_data on the rising edge of in_ack. The downstream side
// acts as a producer: while out_req is high and a word is stored, it answers
// with a one-cycle out_ack and the word on out_data.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        asynchronous active-low reset
//   in_req     request to upstream (at most one outstanding)
//   in_ack     upstream ack, may stay high for several cycles per word
//   in_data    upstream word, sampled on the rising edge of in_ack
//   out_req    request from downstream
//   out_ack    one-cycle pulse per delivered word
//   out_data   delivered word, held until the next delivery
//   occupancy  number of stored words, 0..depth
//   count_in   words accepted since reset (wraps)
//   count_out  words delivered since reset (wraps)
//   overflow   sticky flag: an ack arrived with no free slot
module hs_fifo_stage #(
  parameter  int data_width = 32,
  parameter  int depth      = 4,
  localparam int addr_width = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  in_req,
  input  logic                  in_ack,
  input  logic [data_width-1:0] in_data,
  input  logic                  out_req,
  output logic                  out_ack,
  output logic [data_width-1:0] out_data,
  output logic [addr_width:0]   occupancy,
  output logic [31:0]           count_in,
  output logic [31:0]           count_out,
  output logic                  overflow
);

  localparam logic [addr_width:0] full_lvl = (addr_width + 1)'(depth);

  logic [data_width-1:0] mem_q [depth];

  logic                  in_req_q,    in_req_d;
  logic                  in_ack_q;
  logic                  out_ack_q,   out_ack_d;
  logic [data_width-1:0] out_data_q,  out_data_d;
  logic [addr_width:0]   occ_q,       occ_d;
  logic [addr_width-1:0] wptr_q,      wptr_d;
  logic [addr_width-1:0] rptr_q,      rptr_d;
  logic [31:0]           count_in_q,  count_in_d;
  logic [31:0]           count_out_q, count_out_d;
  logic                  overflow_q,  overflow_d;

  logic accept;   // rising edge of in_ack
  logic deliver;  // word handed downstream this cycle
  logic full;
  logic drop;     // accept with nowhere to put the word
  logic store;    // accept that actually writes memory

  always_comb begin
    accept  = in_ack & ~in_ack_q;
    // out_ack_q blocks a second delivery on the cycle right after a pulse,
    // so out_ack is always a single-cycle pulse.
    deliver = out_req & ~out_ack_q & (occ_q != '0);
    full    = (occ_q == full_lvl);
    // A simultaneous delivery frees the slot the incoming word needs.
    drop    = accept & full & ~deliver;
    store   = accept & ~drop;
  end

  always_comb begin
    in_req_d    = in_req_q;
    out_ack_d   = deliver;
    out_data_d  = out_data_q;
    occ_d       = occ_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_in_d  = count_in_q;
    count_out_d = count_out_q;
    overflow_d  = overflow_q | drop;

    // Only one request is ever outstanding, so a slot is reserved when the
    // request is raised; occupancy cannot grow while we wait for the ack.
    if (accept) begin
      in_req_d = 1'b0;
    end else if (!in_req_q &&
                 ((occ_q - {{addr_width{1'b0}}, deliver}) < full_lvl)) begin
      in_req_d = 1'b1;
    end

    if (store) begin
      wptr_d     = wptr_q + 1'b1;
      count_in_d = count_in_q + 32'd1;
    end

    if (deliver) begin
      out_data_d  = mem_q[rptr_q];
      rptr_d      = rptr_q + 1'b1;
      count_out_d = count_out_q + 32'd1;
    end

    case ({store, deliver})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_req_q    <= 1'b0;
      in_ack_q    <= 1'b0;
      out_ack_q   <= 1'b0;
      out_data_q  <= '0;
      occ_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_in_q  <= '0;
      count_out_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      in_req_q    <= in_req_d;
      in_ack_q    <= in_ack;
      out_ack_q   <= out_ack_d;
      out_data_q  <= out_data_d;
      occ_q       <= occ_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_in_q  <= count_in_d;
      count_out_q <= count_out_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage. When full with a simultaneous accept and deliver, wptr==rptr;
  // the read above sees the old word because the write lands after the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (store) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  assign in_req    = in_req_q;
  assign out_ack   = out_ack_q;
  assign out_data  = out_data_q;
  assign occupancy = occ_q;
  assign count_in  = count_in_q;
  assign count_out = count_out_q;
  assign overflow  = overflow_q;

endmodule
